// File: rtl/hpd_link_ctrl.sv
// HPD debounce and link bring-up controller: debounces the hot-plug pin, drives the tick timer,
// requests sink init, supervises it with a tick timeout and reports link state.
module hpd_link_ctrl #(
   parameter int unsigned TICKS_ON     = 4,
   parameter int unsigned TICKS_OFF    = 2,
   parameter int unsigned INIT_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hpd_in,
   input  logic       timer_tick,
   input  logic       init_done,
   output logic       timer_ena,
   output logic       timer_rst,
   output logic       init_start,
   output logic       link_up,
   output logic       link_down,
   output logic       init_fail,
   output logic [3:0] fail_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StDebOn  = 3'd1,
      StInit   = 3'd2,
      StUp     = 3'd3,
      StDebOff = 3'd4
   } state_e;

   localparam logic [7:0] OnLast   = 8'(TICKS_ON - 1);
   localparam logic [7:0] OffLast  = 8'(TICKS_OFF - 1);
   localparam logic [7:0] InitLast = 8'(INIT_TIMEOUT - 1);

   state_e     st, st_nxt;
   logic [7:0] tick_cnt;
   logic       hpd_m, hpd_s;
   logic       start_evt, fail_evt, down_evt;

   // An HPD drop is tested first in every state so it beats init_done and tick expiry.
   always_comb begin
      st_nxt    = st;
      start_evt = 1'b0;
      fail_evt  = 1'b0;
      down_evt  = 1'b0;
      unique case (st)
         StIdle: begin
            if (hpd_s) st_nxt = StDebOn;
         end
         StDebOn: begin
            if (!hpd_s) begin
               st_nxt = StIdle;
            end else if (timer_tick && tick_cnt == OnLast) begin
               st_nxt    = StInit;
               start_evt = 1'b1;
            end
         end
         StInit: begin
            if (!hpd_s) begin
               st_nxt = StIdle;
            end else if (init_done) begin
               st_nxt = StUp;
            end else if (timer_tick && tick_cnt == InitLast) begin
               st_nxt   = StIdle;
               fail_evt = 1'b1;
            end
         end
         StUp: begin
            if (!hpd_s) st_nxt = StDebOff;
         end
         StDebOff: begin
            if (hpd_s) begin
               st_nxt = StUp;
            end else if (timer_tick && tick_cnt == OffLast) begin
               st_nxt   = StIdle;
               down_evt = 1'b1;
            end
         end
         default: st_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hpd_m      <= 1'b0;
         hpd_s      <= 1'b0;
         st         <= StIdle;
         tick_cnt   <= 8'd0;
         fail_cnt   <= 4'd0;
         timer_ena  <= 1'b0;
         timer_rst  <= 1'b1;
         init_start <= 1'b0;
         init_fail  <= 1'b0;
         link_down  <= 1'b0;
         link_up    <= 1'b0;
      end else begin
         hpd_m <= hpd_in;
         hpd_s <= hpd_m;
         st    <= st_nxt;
         if (st_nxt != st) begin
            tick_cnt <= 8'd0;
         end else if (timer_tick) begin
            tick_cnt <= tick_cnt + 8'd1;
         end
         timer_rst  <= (st_nxt != st);
         timer_ena  <= (st_nxt == StDebOn) || (st_nxt == StInit) || (st_nxt == StDebOff);
         link_up    <= (st_nxt == StUp) || (st_nxt == StDebOff);
         init_start <= start_evt;
         init_fail  <= fail_evt;
         link_down  <= down_evt;
         if (fail_evt && fail_cnt != 4'hf) begin
            fail_cnt <= fail_cnt + 4'd1;
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_hpd_link_ctrl.sv
// Scoreboard bench for hpd_link_ctrl: stimulus queues expected events/snapshots with their cycle,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_hpd_link_ctrl;

   logic       clk, rst, hpd_in, timer_tick, init_done;
   logic       timer_ena, timer_rst, init_start, link_up, link_down, init_fail;
   logic [3:0] fail_cnt;
   logic [2:0] state;

   hpd_link_ctrl #(
      .TICKS_ON    (4),
      .TICKS_OFF   (2),
      .INIT_TIMEOUT(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hpd_in    (hpd_in),
      .timer_tick(timer_tick),
      .init_done (init_done),
      .timer_ena (timer_ena),
      .timer_rst (timer_rst),
      .init_start(init_start),
      .link_up   (link_up),
      .link_down (link_down),
      .init_fail (init_fail),
      .fail_cnt  (fail_cnt),
      .state     (state)
   );

   localparam int KStart = 0, KFail = 1, KDown = 2, KUp = 3, KFall = 4, KSnap = 5;

   typedef struct {
      int         kind;
      int         cyc;
      logic [2:0] st;
      logic       lu;
      logic       ena;
      logic       trst;
      logic [3:0] fc;
   } exp_t;

   exp_t evq[$];
   exp_t snq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   fc_m = 0;
   logic prev_lu = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         KStart:  return "init_start";
         KFail:   return "init_fail";
         KDown:   return "link_down";
         KUp:     return "link_up_rise";
         KFall:   return "link_up_fall";
         default: return "snapshot";
      endcase
   endfunction

   task automatic compare(input exp_t e);
      checks++;
      if (state !== e.st || link_up !== e.lu || timer_ena !== e.ena || timer_rst !== e.trst ||
          fail_cnt !== e.fc) begin
         errors++;
         $display("FAIL %s cyc=%0d got st=%0d lu=%b ena=%b trst=%b fc=%0d required st=%0d lu=%b ena=%b trst=%b fc=%0d",
                  kname(e.kind), cyc, state, link_up, timer_ena, timer_rst, fail_cnt,
                  e.st, e.lu, e.ena, e.trst, e.fc);
      end
   endtask

   task automatic observe(input int k);
      exp_t e;
      if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].kind == k) begin
         e = evq.pop_front();
         compare(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s cyc=%0d got pulse required none", kname(k), cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
         e = evq.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_%s got none required at cyc=%0d", kname(e.kind), e.cyc);
      end
      while (snq.size() > 0 && snq[0].cyc < cyc) begin
         e = snq.pop_front();
         checks++;
         errors++;
         $display("FAIL missed_snapshot got none required at cyc=%0d", e.cyc);
      end
      if (snq.size() > 0 && snq[0].cyc == cyc) begin
         e = snq.pop_front();
         compare(e);
      end
      if (init_start === 1'b1) observe(KStart);
      if (init_fail === 1'b1) observe(KFail);
      if (link_down === 1'b1) observe(KDown);
      if (link_up === 1'b1 && prev_lu !== 1'b1) observe(KUp);
      if (link_up === 1'b0 && prev_lu === 1'b1 && link_down !== 1'b1) observe(KFall);
      prev_lu = link_up;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_snap(input int dc, input logic [2:0] st, input logic lu, input logic ena,
                            input logic trst);
      exp_t e;
      e.kind = KSnap; e.cyc = cyc + dc; e.st = st; e.lu = lu; e.ena = ena; e.trst = trst;
      e.fc = 4'(fc_m);
      snq.push_back(e);
   endtask

   task automatic push_ev(input int k);
      exp_t e;
      e.kind = k;
      e.cyc  = cyc + 1;
      e.trst = 1'b1;
      case (k)
         KStart:  begin e.st = 3'd2; e.lu = 1'b0; e.ena = 1'b1; end
         KUp:     begin e.st = 3'd3; e.lu = 1'b1; e.ena = 1'b0; end
         default: begin e.st = 3'd0; e.lu = 1'b0; e.ena = 1'b0; end
      endcase
      if (k == KFail && fc_m < 15) fc_m++;
      e.fc = 4'(fc_m);
      evq.push_back(e);
   endtask

   // Nine idle cycles then a one-cycle tick; k >= 0 names the event the tick must cause.
   task automatic tick(input int k);
      repeat (9) cycle();
      if (k >= 0) push_ev(k);
      timer_tick = 1'b1;
      cycle();
      timer_tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hpd_in = 1'b0; timer_tick = 1'b0; init_done = 1'b0;
      // Reset
      cycle();
      push_snap(0, 3'd0, 1'b0, 1'b0, 1'b1);
      cycle();
      cycle();
      rst = 1'b0;
      push_snap(1, 3'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      // Stray init_done in IDLE must be ignored
      init_done = 1'b1;
      cycle();
      init_done = 1'b0;
      repeat (3) cycle();

      // Clean plug
      hpd_in = 1'b1;
      repeat (3) tick(-1);
      tick(KStart);
      repeat (4) cycle();
      init_done = 1'b1;
      push_ev(KUp);
      cycle();
      init_done = 1'b0;
      push_snap(1, 3'd3, 1'b1, 1'b0, 1'b0);
      cycle();

      // Unplug glitch shorter than TICKS_OFF
      hpd_in = 1'b0;
      repeat (3) cycle();
      push_snap(0, 3'd4, 1'b1, 1'b1, 1'b1);
      tick(-1);
      hpd_in = 1'b1;
      repeat (3) cycle();
      push_snap(0, 3'd3, 1'b1, 1'b0, 1'b1);
      tick(-1);

      // Real unplug
      hpd_in = 1'b0;
      tick(-1);
      tick(KDown);
      push_snap(1, 3'd0, 1'b0, 1'b0, 1'b0);
      cycle();

      // Bounce during DEB_ON
      hpd_in = 1'b1;
      tick(-1);
      tick(-1);
      hpd_in = 1'b0;
      cycle();
      hpd_in = 1'b1;
      cycle();
      cycle();
      push_snap(0, 3'd0, 1'b0, 1'b0, 1'b1);
      push_snap(1, 3'd1, 1'b0, 1'b1, 1'b1);
      repeat (3) tick(-1);
      tick(KStart);

      // Timeout and automatic retry, 20 rounds to saturate fail_cnt
      for (int i = 0; i < 20; i++) begin
         repeat (15) tick(-1);
         tick(KFail);
         repeat (3) tick(-1);
         tick(KStart);
      end

      // Collision: HPD drop and init_done in the same cycle while in INIT
      hpd_in = 1'b0;
      cycle();
      cycle();
      init_done = 1'b1;
      push_snap(1, 3'd0, 1'b0, 1'b0, 1'b1);
      cycle();
      init_done = 1'b0;
      repeat (5) cycle();
      push_snap(1, 3'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      repeat (3) cycle();

      checks++;
      if (evq.size() != 0 || snq.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got %0d left required 0", evq.size() + snq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
